alarm_ctrl: RTL

Alarm-setting and alarm-ringing controller for the electronic clock. It stores two BCD alarm times with enable flags and edits them from debounced key pulses while the alarm display mode is active. It compares them against the running time and drives the buzzer. Its outputs feed the digit display stage directly: the alarm data words, the selected-alarm index and the per-digit blink mask.

---
 rtl/alarm_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: stores two BCD alarm times with enable flags, edits them from
// debounced key pulses while the alarm display mode is active, and rings the
// buzzer when the running time reaches an enabled alarm.
// Optional feature: define ALARM_SNOOZE_EN to add a snooze state.
module alarm_ctrl #(
  parameter int unsigned RING_SEC   = 30,
  parameter int unsigned SNOOZE_SEC = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode_active,
  input  logic        key_sel,
  input  logic        key_field,
  input  logic        key_inc,
  input  logic        key_stop,
  input  logic [23:0] clock_data,
  input  logic        sec_tick,
  output logic [19:0] alarm_data_1,
  output logic [19:0] alarm_data_2,
  output logic [3:0]  alarm_data_mode,
  output logic [5:0]  mode_seg,
  output logic        ringing,
  output logic        buzzer
);

  typedef enum logic [1:0] {F_HOUR, F_MIN, F_EN} field_e;
`ifdef ALARM_SNOOZE_EN
  typedef enum logic [1:0] {R_IDLE, R_RING, R_SNOOZE} ring_e;
`else
  typedef enum logic {R_IDLE, R_RING} ring_e;
`endif

  typedef struct packed {
    logic       en;
    logic [7:0] hh;
    logic [7:0] mm;
  } alarm_t;

  localparam alarm_t     ALARM_1_RST = '{en: 1'b0, hh: 8'h07, mm: 8'h00};
  localparam alarm_t     ALARM_2_RST = '{en: 1'b0, hh: 8'h07, mm: 8'h30};
  localparam logic [7:0] RING_LAST   = 8'(RING_SEC - 1);

  // BCD increment that wraps from 'top' back to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    if (v == top)             return 8'h00;
    else if (v[3:0] == 4'd9)  return {v[7:4] + 4'd1, 4'd0};
    else                      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  field_e     field_q, field_d;
  logic       sel_q, sel_d;          // 0 = alarm 1, 1 = alarm 2
  alarm_t     alarm_1_q, alarm_1_d;
  alarm_t     alarm_2_q, alarm_2_d;
  alarm_t     edit;
  logic [5:0] mode_seg_q, mode_seg_d;

  ring_e      ring_q, ring_d;
  logic [7:0] ring_cnt_q, ring_cnt_d;
  logic       buzzer_q, buzzer_d;
  logic       match;

`ifdef ALARM_SNOOZE_EN
  localparam logic [9:0] SNOOZE_LAST = 10'(SNOOZE_SEC - 1);
  logic [9:0] snooze_cnt_q, snooze_cnt_d;
`else
  logic [9:0] snooze_unused;
  assign snooze_unused = 10'(SNOOZE_SEC);
`endif

  // An alarm fires only at second 00 of its hh:mm, and only if enabled.
  assign match = sec_tick && (clock_data[7:0] == 8'h00) &&
                 ((alarm_1_q.en && (clock_data[23:8] == {alarm_1_q.hh, alarm_1_q.mm})) ||
                  (alarm_2_q.en && (clock_data[23:8] == {alarm_2_q.hh, alarm_2_q.mm})));

  // Edit FSM: key decoding with sel > field > inc priority, plus blink mask.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    field_d   = field_q;
    sel_d     = sel_q;
    alarm_1_d = alarm_1_q;
    alarm_2_d = alarm_2_q;
    edit      = sel_q ? alarm_2_q : alarm_1_q;

    if (!mode_active) begin
      field_d = F_HOUR;
    end else if (key_sel) begin
      sel_d   = ~sel_q;
      field_d = F_HOUR;
    end else if (key_field) begin
      case (field_q)
        F_HOUR:  field_d = F_MIN;
        F_MIN:   field_d = F_EN;
        default: field_d = F_HOUR;
      endcase
    end else if (key_inc) begin
      case (field_q)
        F_HOUR:  edit.hh = bcd_inc(edit.hh, 8'h23);
        F_MIN:   edit.mm = bcd_inc(edit.mm, 8'h59);
        default: edit.en = ~edit.en;
      endcase
      if (sel_q) alarm_2_d = edit;
      else       alarm_1_d = edit;
    end

    if (!mode_active) begin
      mode_seg_d = 6'h3F;
    end else begin
      case (field_d)
        F_HOUR:  mode_seg_d = 6'b001111;
        F_MIN:   mode_seg_d = 6'b110011;
        default: mode_seg_d = 6'b111101;
      endcase
    end
  end

  // Ring FSM: start on match, time out after RING_SEC ticks, stop on key_stop.
  always_comb begin
    ring_d     = ring_q;
    ring_cnt_d = ring_cnt_q;
    buzzer_d   = buzzer_q;
`ifdef ALARM_SNOOZE_EN
    snooze_cnt_d = snooze_cnt_q;
`endif
    case (ring_q)
      R_IDLE: begin
        if (match) begin
          ring_d     = R_RING;
          ring_cnt_d = '0;
          buzzer_d   = 1'b1;
        end
      end
      R_RING: begin
        if (key_stop) begin
`ifdef ALARM_SNOOZE_EN
          ring_d       = R_SNOOZE;
          snooze_cnt_d = '0;
`else
          ring_d       = R_IDLE;
`endif
          buzzer_d = 1'b0;
        end else if (sec_tick) begin
          if (ring_cnt_q == RING_LAST) begin
            ring_d   = R_IDLE;
            buzzer_d = 1'b0;
          end else begin
            ring_cnt_d = ring_cnt_q + 8'd1;
            buzzer_d   = ~buzzer_q;
          end
        end
      end
`ifdef ALARM_SNOOZE_EN
      R_SNOOZE: begin
        if (key_stop) begin
          ring_d = R_IDLE;
        end else if (match || (sec_tick && (snooze_cnt_q == SNOOZE_LAST))) begin
          ring_d     = R_RING;
          ring_cnt_d = '0;
          buzzer_d   = 1'b1;
        end else if (sec_tick) begin
          snooze_cnt_d = snooze_cnt_q + 10'd1;
        end
      end
`endif
      default: begin
        ring_d   = R_IDLE;
        buzzer_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      field_q    <= F_HOUR;
      sel_q      <= 1'b0;
      alarm_1_q  <= ALARM_1_RST;
      alarm_2_q  <= ALARM_2_RST;
      mode_seg_q <= 6'h3F;
      ring_q     <= R_IDLE;
      ring_cnt_q <= '0;
      buzzer_q   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snooze_cnt_q <= '0;
`endif
    end else begin
      field_q    <= field_d;
      sel_q      <= sel_d;
      alarm_1_q  <= alarm_1_d;
      alarm_2_q  <= alarm_2_d;
      mode_seg_q <= mode_seg_d;
      ring_q     <= ring_d;
      ring_cnt_q <= ring_cnt_d;
      buzzer_q   <= buzzer_d;
`ifdef ALARM_SNOOZE_EN
      snooze_cnt_q <= snooze_cnt_d;
`endif
    end
  end

  assign alarm_data_1    = {3'b000, alarm_1_q};
  assign alarm_data_2    = {3'b000, alarm_2_q};
  assign alarm_data_mode = sel_q ? 4'd2 : 4'd1;
  assign mode_seg        = mode_seg_q;
  assign ringing         = (ring_q == R_RING);
  assign buzzer          = buzzer_q;

endmodule
